// File: rtl/apb_timeout_splitter_if.sv
// Bus bundle for apb_timeout_splitter: upstream APB port plus the replicated/qualified
// downstream slave ports. Modport slave is the splitter's view, modport master the environment's.
interface apb_timeout_splitter_if #(
  parameter int W_ADDR   = 16,
  parameter int W_DATA   = 32,
  parameter int N_SLAVES = 3
);
  logic [W_ADDR-1:0]          apbs_paddr;
  logic                       apbs_psel;
  logic                       apbs_penable;
  logic                       apbs_pwrite;
  logic [W_DATA-1:0]          apbs_pwdata;
  logic                       apbs_pready;
  logic [W_DATA-1:0]          apbs_prdata;
  logic                       apbs_pslverr;
  logic [W_DATA-1:0]          apbs_phartid;

  logic [N_SLAVES*W_ADDR-1:0] apbm_paddr;
  logic [N_SLAVES*W_DATA-1:0] apbm_pwdata;
  logic [N_SLAVES*W_DATA-1:0] apbm_hartid;
  logic [N_SLAVES-1:0]        apbm_psel;
  logic [N_SLAVES-1:0]        apbm_penable;
  logic [N_SLAVES-1:0]        apbm_pwrite;
  logic [N_SLAVES-1:0]        apbm_pready;
  logic [N_SLAVES-1:0]        apbm_pslverr;
  logic [N_SLAVES*W_DATA-1:0] apbm_prdata;

  modport slave (
    input  apbs_paddr, apbs_psel, apbs_penable, apbs_pwrite, apbs_pwdata, apbs_phartid,
    output apbs_pready, apbs_prdata, apbs_pslverr,
    output apbm_paddr, apbm_pwdata, apbm_hartid, apbm_psel, apbm_penable, apbm_pwrite,
    input  apbm_pready, apbm_pslverr, apbm_prdata
  );

  modport master (
    output apbs_paddr, apbs_psel, apbs_penable, apbs_pwrite, apbs_pwdata, apbs_phartid,
    input  apbs_pready, apbs_prdata, apbs_pslverr,
    input  apbm_paddr, apbm_pwdata, apbm_hartid, apbm_psel, apbm_penable, apbm_pwrite,
    output apbm_pready, apbm_pslverr, apbm_prdata
  );
endinterface

// File: rtl/apb_timeout_splitter.sv
// APB 1-to-N address splitter with zero-wait pass-through and error response for unmapped hits.
// Optional per-access wait timeout enabled by defining APB_TIMEOUT_SPLITTER_TIMEOUT_EN.
module apb_timeout_splitter #(
  parameter int                           W_ADDR         = 16,
  parameter int                           W_DATA         = 32,
  parameter int                           N_SLAVES       = 3,
  parameter logic [N_SLAVES*W_ADDR-1:0]   ADDR_MAP       = 48'h4000_2000_0000,
  parameter logic [N_SLAVES*W_ADDR-1:0]   ADDR_MASK      = 48'he000_e000_e000,
  parameter int                           W_TIMEOUT      = 8,
  parameter int                           TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  apb_timeout_splitter_if.slave       bus,
  output logic                        timeout_pulse
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << W_TIMEOUT)) begin : g_bad_timeout
    $error("apb_timeout_splitter: TIMEOUT_CYCLES must lie in 1 .. 2**W_TIMEOUT-1");
  end

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              state, state_nxt;
  logic [N_SLAVES-1:0] sel_q, sel_nxt;
  logic [N_SLAVES-1:0] hit, dec;
  logic                sel_ready;
  logic                sel_err;
  logic [W_DATA-1:0]   sel_rdata;
  logic                timeout_hit;

  assign bus.apbm_paddr  = {N_SLAVES{bus.apbs_paddr}};
  assign bus.apbm_pwdata = {N_SLAVES{bus.apbs_pwdata}};
  assign bus.apbm_hartid = {N_SLAVES{bus.apbs_phartid}};

  // Address decode; the lowest matching index wins so the result is always one-hot or zero.
  always_comb begin
    hit = '0;
    dec = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      hit[i] = (bus.apbs_paddr & ADDR_MASK[i*W_ADDR +: W_ADDR]) == ADDR_MAP[i*W_ADDR +: W_ADDR];
    end
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        dec    = '0;
        dec[i] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel_q[i]) begin
        sel_ready = sel_ready | bus.apbm_pready[i];
        sel_err   = sel_err   | bus.apbm_pslverr[i];
        sel_rdata = sel_rdata | bus.apbm_prdata[i*W_DATA +: W_DATA];
      end
    end
  end

`ifdef APB_TIMEOUT_SPLITTER_TIMEOUT_EN
  localparam logic [W_TIMEOUT-1:0] TO_LIMIT = W_TIMEOUT'(TIMEOUT_CYCLES);

  logic [W_TIMEOUT-1:0] cnt_q, cnt_nxt;

  function automatic logic [W_TIMEOUT-1:0] sat_inc(input logic [W_TIMEOUT-1:0] v);
    return (v >= TO_LIMIT) ? TO_LIMIT : v + W_TIMEOUT'(1);
  endfunction

  // Held at zero while idle, so every access starts counting from a fresh setup phase.
  always_comb begin
    cnt_nxt = cnt_q;
    if (state == IDLE) begin
      cnt_nxt = '0;
    end else if (!sel_ready) begin
      cnt_nxt = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_nxt;
    end
  end

  assign timeout_hit = (state == ACCESS) && (sel_q != '0) && bus.apbs_psel &&
                       !sel_ready && (cnt_q == TO_LIMIT);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel_q <= '0;
    end else begin
      state <= state_nxt;
      sel_q <= sel_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    sel_nxt          = sel_q;
    bus.apbm_psel    = '0;
    bus.apbm_penable = '0;
    bus.apbm_pwrite  = '0;
    bus.apbs_pready  = 1'b0;
    bus.apbs_pslverr = 1'b0;
    bus.apbs_prdata  = '0;
    timeout_pulse    = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (bus.apbs_penable) begin
            // Enable without a preceding setup phase: reject it and stay idle.
            bus.apbs_pready  = 1'b1;
            bus.apbs_pslverr = 1'b1;
          end else if (bus.apbs_psel) begin
            bus.apbm_psel   = dec;
            bus.apbm_pwrite = dec & {N_SLAVES{bus.apbs_pwrite}};
            sel_nxt         = dec;
            state_nxt       = ACCESS;
          end
        end
        ACCESS: begin
          if (sel_q == '0) begin
            bus.apbs_pready  = 1'b1;
            bus.apbs_pslverr = 1'b1;
            state_nxt        = IDLE;
          end else if (timeout_hit) begin
            bus.apbs_pready  = 1'b1;
            bus.apbs_pslverr = 1'b1;
            timeout_pulse    = 1'b1;
            state_nxt        = IDLE;
          end else begin
            bus.apbm_psel    = sel_q & {N_SLAVES{bus.apbs_psel}};
            bus.apbm_penable = sel_q & {N_SLAVES{bus.apbs_penable}};
            bus.apbm_pwrite  = sel_q & {N_SLAVES{bus.apbs_pwrite}};
            bus.apbs_pready  = sel_ready;
            bus.apbs_pslverr = sel_err;
            bus.apbs_prdata  = sel_rdata;
            if (sel_ready || !bus.apbs_psel) begin
              state_nxt = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_timeout_splitter.sv
// Directed plus randomized bench for apb_timeout_splitter with a transaction-level reference model.
// Slave 1 and slave 2 decodes overlap on 0x2000-0x3fff so lowest-index priority is exercised.
module tb_apb_timeout_splitter;
  localparam int W_ADDR = 16;
  localparam int W_DATA = 32;
  localparam int N      = 3;
  localparam int TO     = 4;
`ifdef APB_TIMEOUT_SPLITTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic timeout_pulse;
  int   ntests = 0;
  int   nfail  = 0;

  logic [15:0] ref_map  [N] = '{16'h0000, 16'h2000, 16'h2000};
  logic [15:0] ref_mask [N] = '{16'he000, 16'he000, 16'h2000};

  apb_timeout_splitter_if #(.W_ADDR(W_ADDR), .W_DATA(W_DATA), .N_SLAVES(N)) bus ();

  apb_timeout_splitter #(
    .W_ADDR(W_ADDR), .W_DATA(W_DATA), .N_SLAVES(N),
    .ADDR_MAP({16'h2000, 16'h2000, 16'h0000}),
    .ADDR_MASK({16'h2000, 16'he000, 16'he000}),
    .W_TIMEOUT(8), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic int ref_decode(input logic [15:0] addr);
    for (int i = 0; i < N; i++) begin
      if ((addr & ref_mask[i]) == ref_map[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int t);
    logic [N-1:0] v = '0;
    if (t >= 0) v[t] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_slaves(input int tgt, input logic rdy, input logic err, input logic [31:0] rd);
    for (int i = 0; i < N; i++) begin
      if (i == tgt) begin
        bus.apbm_pready[i]           = rdy;
        bus.apbm_pslverr[i]          = err;
        bus.apbm_prdata[i*32 +: 32]  = rd;
      end else begin
        bus.apbm_pready[i]           = 1'($urandom);
        bus.apbm_pslverr[i]          = 1'($urandom);
        bus.apbm_prdata[i*32 +: 32]  = $urandom;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      bus.apbs_psel    = 1'b0;
      bus.apbs_penable = 1'b0;
      bus.apbs_paddr   = 16'($urandom);
      drive_slaves(-1, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      chk("idle_psel", bus.apbm_psel, '0);
      chk("idle_pready", bus.apbs_pready, 1'b0);
      chk("idle_pulse", timeout_pulse, 1'b0);
      next_cycle();
    end
  endtask

  // Whole APB transfer; the target slave raises pready after 'waits' access cycles.
  task automatic do_xfer(input string name, input logic [15:0] addr, input logic wr,
                         input int waits, input logic err);
    int          tgt   = ref_decode(addr);
    logic [31:0] rdata = $urandom;
    logic [31:0] wdata = $urandom;
    logic [31:0] hart  = $urandom;
    bit          done  = 1'b0;
    bit          exp_to, exp_done;
    bus.apbs_paddr   = addr;
    bus.apbs_psel    = 1'b1;
    bus.apbs_penable = 1'b0;
    bus.apbs_pwrite  = wr;
    bus.apbs_pwdata  = wdata;
    bus.apbs_phartid = hart;
    drive_slaves(tgt, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk({name, "_setup_psel"}, bus.apbm_psel, onehot(tgt));
    chk({name, "_setup_penable"}, bus.apbm_penable, '0);
    chk({name, "_paddr_rep"}, bus.apbm_paddr, {N{addr}});
    chk({name, "_pwdata_rep"}, bus.apbm_pwdata, {N{wdata}});
    chk({name, "_hartid_rep"}, bus.apbm_hartid, {N{hart}});
    next_cycle();
    bus.apbs_penable = 1'b1;
    for (int cyc = 0; !done; cyc++) begin
      exp_to   = TO_EN && (tgt >= 0) && (waits > TO) && (cyc == TO);
      exp_done = (tgt < 0) || exp_to || (cyc == waits);
      drive_slaves(tgt, cyc == waits, err, rdata);
      @(negedge clk);
      chk({name, "_psel"}, bus.apbm_psel, (tgt >= 0 && !exp_to) ? onehot(tgt) : '0);
      chk({name, "_penable"}, bus.apbm_penable, (tgt >= 0 && !exp_to) ? onehot(tgt) : '0);
      if (tgt >= 0 && !exp_to)
        chk({name, "_pwrite"}, bus.apbm_pwrite, wr ? onehot(tgt) : '0);
      chk({name, "_pready"}, bus.apbs_pready, exp_done);
      chk({name, "_pulse"}, timeout_pulse, exp_to);
      if (exp_done) begin
        chk({name, "_pslverr"}, bus.apbs_pslverr, (tgt < 0 || exp_to) ? 1'b1 : err);
        chk({name, "_prdata"}, bus.apbs_prdata, (tgt < 0 || exp_to) ? 32'h0 : rdata);
      end
      next_cycle();
      done = exp_done;
    end
    bus.apbs_psel    = 1'b0;
    bus.apbs_penable = 1'b0;
  endtask

  initial begin
    rst              = 1'b1;
    bus.apbs_paddr   = 16'h0000;
    bus.apbs_psel    = 1'b1;
    bus.apbs_penable = 1'b1;
    bus.apbs_pwrite  = 1'b0;
    bus.apbs_pwdata  = '0;
    bus.apbs_phartid = '0;
    drive_slaves(-1, 1'b0, 1'b0, 32'h0);
    next_cycle();

    // Outputs held quiet while reset is asserted, whatever the upstream does.
    @(negedge clk);
    chk("rst_pready", bus.apbs_pready, 1'b0);
    chk("rst_pslverr", bus.apbs_pslverr, 1'b0);
    chk("rst_psel", bus.apbm_psel, '0);
    chk("rst_pulse", timeout_pulse, 1'b0);
    next_cycle();
    bus.apbs_penable = 1'b0;
    @(negedge clk);
    chk("rst_setup_psel", bus.apbm_psel, '0);
    chk("rst_setup_penable", bus.apbm_penable, '0);
    next_cycle();
    rst = 1'b0;
    idle_cycles(2);

    do_xfer("wr_s1", 16'h2004, 1'b1, 2, 1'b0);
    idle_cycles(1);
    do_xfer("rd_unmapped", 16'h8000, 1'b0, 0, 1'b0);
    do_xfer("rd_s2", 16'h6010, 1'b0, 1, 1'b0);
    do_xfer("to_s0", 16'h0040, 1'b0, 10, 1'b0);
    idle_cycles(1);
    do_xfer("late_ready_s0", 16'h0044, 1'b0, TO, 1'b1);

    // Enable without setup from idle is rejected and the splitter stays idle.
    bus.apbs_paddr   = 16'h0000;
    bus.apbs_psel    = 1'b1;
    bus.apbs_penable = 1'b1;
    drive_slaves(-1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("viol_pready", bus.apbs_pready, 1'b1);
    chk("viol_pslverr", bus.apbs_pslverr, 1'b1);
    chk("viol_prdata", bus.apbs_prdata, 32'h0);
    chk("viol_psel", bus.apbm_psel, '0);
    next_cycle();
    do_xfer("after_viol", 16'h0100, 1'b1, 0, 1'b0);

    // Upstream abandons an access just as the wait limit is reached: no timeout.
    bus.apbs_paddr   = 16'h0200;
    bus.apbs_psel    = 1'b1;
    bus.apbs_penable = 1'b0;
    drive_slaves(0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    bus.apbs_penable = 1'b1;
    for (int c = 0; c < TO; c++) begin
      drive_slaves(0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      chk("drop_wait_psel", bus.apbm_psel, 3'b001);
      chk("drop_wait_pready", bus.apbs_pready, 1'b0);
      next_cycle();
    end
    bus.apbs_psel    = 1'b0;
    bus.apbs_penable = 1'b0;
    drive_slaves(0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("drop_psel", bus.apbm_psel, '0);
    chk("drop_pready", bus.apbs_pready, 1'b0);
    chk("drop_pulse", timeout_pulse, 1'b0);
    next_cycle();
    idle_cycles(1);

    // Reset in the middle of an access to slave 2, then a clean read from slave 0.
    bus.apbs_paddr   = 16'h6000;
    bus.apbs_psel    = 1'b1;
    bus.apbs_penable = 1'b0;
    drive_slaves(2, 1'b0, 1'b0, 32'h0);
    next_cycle();
    bus.apbs_penable = 1'b1;
    @(negedge clk);
    chk("rstmid_psel_before", bus.apbm_psel, 3'b100);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_psel_during", bus.apbm_psel, '0);
    chk("rstmid_pready_during", bus.apbs_pready, 1'b0);
    next_cycle();
    rst              = 1'b0;
    bus.apbs_psel    = 1'b0;
    bus.apbs_penable = 1'b0;
    @(negedge clk);
    chk("rstmid_psel_after", bus.apbm_psel, '0);
    chk("rstmid_pready_after", bus.apbs_pready, 1'b0);
    next_cycle();
    do_xfer("rstmid_rd_s0", 16'h0010, 1'b0, 1, 1'b0);

    do_xfer("long_wait_s0", 16'h0080, 1'b0, 1000, 1'b0);
    idle_cycles(1);

    for (int t = 0; t < 40; t++) begin
      do_xfer("rand", 16'($urandom), 1'($urandom), int'($urandom_range(0, 6)), 1'($urandom));
      idle_cycles(int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
